// File: rtl/up_down_counter_5bit.sv
// Loadable up/down counter that saturates at 0 and at all-ones, with terminal-value flags.
// Priority per edge: load, then down, then up, then hold.
module up_down_counter_5bit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IN,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] Counter,
  output logic             high,
  output logic             low
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == MAX_VAL);
  assign at_zero = (count_q == ZERO_VAL);

  // A blocked decrement at zero still takes priority, so up is ignored there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = IN;
    end else if (down) begin
      if (!at_zero) begin
        count_d = count_q - ONE_VAL;
      end
    end else if (up) begin
      if (!at_max) begin
        count_d = count_q + ONE_VAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= ZERO_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign Counter = count_q;
  assign high    = at_max;
  assign low     = at_zero;

endmodule

// File: tb/tb_up_down_counter_5bit.sv
// Directed, table-driven bench for up_down_counter_5bit with hand-written
// sequences for reset, saturation and asynchronous reset.
module tb_up_down_counter_5bit;

  localparam int WIDTH = 5;
  localparam logic [WIDTH-1:0] MAXV = 5'd31;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] IN;
  logic             load, up, down;
  logic [WIDTH-1:0] Counter;
  logic             high, low;

  int checks_total  = 0;
  int checks_passed = 0;

  up_down_counter_5bit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IN      (IN),
    .load    (load),
    .up      (up),
    .down    (down),
    .Counter (Counter),
    .high    (high),
    .low     (low)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             load;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [WIDTH-1:0] exp);
    logic exp_high, exp_low;
    exp_high = (exp == MAXV);
    exp_low  = (exp == 5'd0);
    checks_total++;
    if (Counter === exp && high === exp_high && low === exp_low) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got Counter=%0d high=%b low=%b, required Counter=%0d high=%b low=%b",
               name, Counter, high, low, exp, exp_high, exp_low);
    end
  endtask

  // Drive on the falling edge, let one rising edge sample, observe 1 time unit later.
  task automatic step(input logic l, input logic u, input logic d, input logic [WIDTH-1:0] v);
    @(negedge clk);
    load = l; up = u; down = d; IN = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; IN = 5'b10101; up = 1'b0; down = 1'b0;

    // Reset held while load is requested and the clock runs.
    #1;
    check("reset_initial", 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_edge%0d", i), 5'd0);
    end
    @(negedge clk);
    load = 1'b0; rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd0);
    check("after_release", 5'd0);

    // Load, hold, increment, priority, and low saturation.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd3,  5'd3};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0,  5'd3};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd4};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd3};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'd9,  5'd9};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd3,  5'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5'd31, 5'd31};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 5'd0,  5'd31};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd30};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0};
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].load, vecs[i].up, vecs[i].down, vecs[i].in);
      $display("vec %0d: load=%b up=%b down=%b IN=%0d -> Counter=%0d (expect %0d)",
               i, vecs[i].load, vecs[i].up, vecs[i].down, vecs[i].in, Counter, vecs[i].exp);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // High saturation: 33 up edges from 0 reach 31 on edge 31 and stay there.
    for (int e = 1; e <= 33; e++) begin
      step(1'b0, 1'b1, 1'b0, 5'd0);
      check($sformatf("up_edge%0d", e), (e >= 31) ? MAXV : 5'(e));
    end
    step(1'b0, 1'b0, 1'b1, 5'd0);
    check("down_from_max", 5'd30);

    // Asynchronous reset between edges while counting up.
    step(1'b1, 1'b0, 1'b0, 5'd17);
    check("load17", 5'd17);
    @(negedge clk);
    load = 1'b0; up = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", 5'd0);
    @(posedge clk);
    #1;
    check("async_reset_held", 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_release", 5'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
